uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver (start + DBIT data bits, LSB first,
// optional even-parity bit, stop bit). Define UART_RX_PARITY_EN to enable the
// parity bit and the parity_err flag; without it parity_err is constant 0.
module uart_rx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done_tick,
  output logic       frame_err,
  output logic       parity_err
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t     state;
  logic [3:0] s;
  logic [2:0] n;
  logic [7:0] b;
  logic [7:0] b_shift;
  logic       rx_q1;
  logic       rx_s;

`ifdef UART_RX_PARITY_EN
  logic       par_bit;
`endif

  // Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q1 <= 1'b1;
      rx_s  <= 1'b1;
    end else begin
      rx_q1 <= rx;
      rx_s  <= rx_q1;
    end
  end

  // Shift right with the sampled bit entering the top data position; bits above
  // DBIT-1 stay zero because they only ever receive zeros from above.
  always_comb begin
    b_shift          = b >> 1;
    b_shift[DBIT-1]  = rx_s;
  end

  // Receive FSM with counters, shift register and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      s            <= 4'd0;
      n            <= 3'd0;
      b            <= 8'd0;
      dout         <= 8'd0;
      rx_done_tick <= 1'b0;
      frame_err    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err   <= 1'b0;
`endif
    end else begin
      rx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          // Start-bit edge is taken immediately, without waiting for s_tick.
          if (!rx_s) begin
            state <= START;
            s     <= 4'd0;
          end
        end
        START: begin
          if (s_tick) begin
            if (s == 4'd7) begin
              if (!rx_s) begin
                state <= DATA;
                s     <= 4'd0;
                n     <= 3'd0;
              end else begin
                state <= IDLE;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        DATA: begin
          if (s_tick) begin
            if (s == 4'd15) begin
              b <= b_shift;
              s <= 4'd0;
              if (n == 3'(DBIT - 1)) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end else begin
                n <= n + 3'd1;
              end
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        PARITY: begin
`ifdef UART_RX_PARITY_EN
          if (s_tick) begin
            if (s == 4'd15) begin
              par_bit <= rx_s;
              s       <= 4'd0;
              state   <= STOP;
            end else begin
              s <= s + 4'd1;
            end
          end
`else
          state <= IDLE;
`endif
        end
        STOP: begin
          if (s_tick) begin
            if (s == 4'(SB_TICK - 1)) begin
              state        <= IDLE;
              dout         <= b;
              frame_err    <= ~rx_s;
              rx_done_tick <= 1'b1;
`ifdef UART_RX_PARITY_EN
              parity_err   <= (^b) ^ par_bit;
`endif
            end else begin
              s <= s + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifndef UART_RX_PARITY_EN
  assign parity_err = 1'b0;
`endif

endmodule
